// File: rtl/datapath_pkg.sv
// Shared types for the PC sequencing datapath.
// Imported by pc_sequencer and pc_pending_redirect.
package datapath_pkg;

  typedef enum logic [1:0] {
    S_RESET,
    S_RUN,
    S_HOLD,
    S_HOLD_PEND
  } pc_state_t;

  typedef enum logic [1:0] {
    RD_NONE,
    RD_BRANCH,
    RD_JUMP
  } redirect_kind_t;

  localparam int PC_INCR = 4;

endpackage

// File: rtl/pc_pending_redirect.sv
// One-entry redirect buffer used while the PC is stalled.
// A branch overrides anything buffered; a jump never displaces a branch.
module pc_pending_redirect
  import datapath_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             wr_branch,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             wr_jump,
  input  logic [WIDTH-1:0] jump_target,
  output logic             valid,
  output redirect_kind_t   kind,
  output logic [WIDTH-1:0] target
);

  always_ff @(posedge clk) begin
    if (clear) begin
      kind   <= RD_NONE;
      target <= '0;
    end else if (wr_branch) begin
      kind   <= RD_BRANCH;
      target <= branch_target;
    end else if (wr_jump && kind != RD_BRANCH) begin
      kind   <= RD_JUMP;
      target <= jump_target;
    end
  end

  assign valid = (kind != RD_NONE);

endmodule

// File: rtl/pc_sequencer.sv
// PC stage: FSM, next-PC mux, PC/PCPlus4/Flush registers.
// Optional PC_SEQ_ALIGN_CHECK_EN traps misaligned redirects.
module pc_sequencer
  import datapath_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
`ifdef PC_SEQ_ALIGN_CHECK_EN
  ,
  parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(32'h0000_0080)
`endif
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Stall,
  input  logic             BranchTaken,
  input  logic [WIDTH-1:0] BranchTarget,
  input  logic             Jump,
  input  logic [WIDTH-1:0] JumpTarget,
  output logic [WIDTH-1:0] PCResult,
  output logic [WIDTH-1:0] PCPlus4,
  output logic             FetchValid,
  output logic             Flush
`ifdef PC_SEQ_ALIGN_CHECK_EN
  ,
  output logic             MisalignErr
`endif
);

  localparam logic [WIDTH-1:0] INCR = WIDTH'(PC_INCR);

  pc_state_t        state;
  logic             pend_valid;
  redirect_kind_t   pend_kind;
  logic [WIDTH-1:0] pend_target;
  logic             pend_clear;
  logic             pend_wr_br;
  logic             pend_wr_jp;
  logic             live;
  logic             redir;
  logic             mis;
  logic [WIDTH-1:0] tgt;
  logic [WIDTH-1:0] nxt;

  assign live       = (state != S_RESET);
  assign pend_clear = Reset || !Stall;
  assign pend_wr_br = live && Stall && BranchTaken;
  assign pend_wr_jp = live && Stall && Jump;

  pc_pending_redirect #(
    .WIDTH(WIDTH)
  ) u_pend (
    .clk          (Clk),
    .clear        (pend_clear),
    .wr_branch    (pend_wr_br),
    .branch_target(BranchTarget),
    .wr_jump      (pend_wr_jp),
    .jump_target  (JumpTarget),
    .valid        (pend_valid),
    .kind         (pend_kind),
    .target       (pend_target)
  );

  always_comb begin
    redir = 1'b1;
    tgt   = PCPlus4;
    if (BranchTaken) begin
      tgt = BranchTarget;
    end else if (pend_valid && pend_kind != RD_NONE) begin
      tgt = pend_target;
    end else if (Jump) begin
      tgt = JumpTarget;
    end else begin
      redir = 1'b0;
    end
  end

  // Alignment is judged on the target actually being applied.
`ifdef PC_SEQ_ALIGN_CHECK_EN
  assign mis = redir && (tgt[1:0] != 2'b00);
  assign nxt = mis ? EXC_VECTOR : tgt;
`else
  assign mis = 1'b0;
  assign nxt = redir ? {tgt[WIDTH-1:2], 2'b00} : tgt;
`endif

  logic mis_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= S_RESET;
      PCResult   <= RESET_PC;
      PCPlus4    <= RESET_PC + INCR;
      FetchValid <= 1'b0;
      Flush      <= 1'b0;
      mis_q      <= 1'b0;
    end else begin
      Flush <= 1'b0;
      mis_q <= 1'b0;
      unique case (state)
        S_RESET: begin
          state      <= S_RUN;
          FetchValid <= 1'b1;
        end
        default: begin
          if (Stall) begin
            if (pend_valid || BranchTaken || Jump)
              state <= S_HOLD_PEND;
            else
              state <= S_HOLD;
          end else begin
            state    <= S_RUN;
            PCResult <= nxt;
            PCPlus4  <= nxt + INCR;
            Flush    <= redir;
            mis_q    <= mis;
          end
        end
      endcase
    end
  end

`ifdef PC_SEQ_ALIGN_CHECK_EN
  assign MisalignErr = mis_q;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer.
// Covers PC_SEQ_ALIGN_CHECK_EN builds as well.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        br;
  logic [31:0] br_tgt;
  logic        jp;
  logic [31:0] jp_tgt;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic        fv;
  logic        flush;
  logic        mis;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .Clk         (clk),
    .Reset       (rst),
    .Stall       (stall),
    .BranchTaken (br),
    .BranchTarget(br_tgt),
    .Jump        (jp),
    .JumpTarget  (jp_tgt),
    .PCResult    (pc),
    .PCPlus4     (pc4),
    .FetchValid  (fv),
    .Flush       (flush)
`ifdef PC_SEQ_ALIGN_CHECK_EN
    ,
    .MisalignErr (mis)
`endif
  );

`ifndef PC_SEQ_ALIGN_CHECK_EN
  assign mis = 1'b0;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall = 0; br = 0; jp = 0;
    br_tgt = '0; jp_tgt = '0;
  endtask

  task automatic chk_pc(input string n, input logic [31:0] e);
    checks++;
    if (pc !== e) begin
      errors++;
      $display("FAIL %s pc got=%h want=%h", n, pc, e);
    end
  endtask

  task automatic test_reset();
    idle();
    rst = 1;
    tick();
    chk_pc("rst", 32'h0);
    checks++;
    if (pc4 !== 32'h4) begin errors++; $display("FAIL rst_pc4 got=%h want=4", pc4); end
    checks++;
    if (fv !== 1'b0) begin errors++; $display("FAIL rst_fv got=%b want=0", fv); end
    checks++;
    if (flush !== 1'b0) begin errors++; $display("FAIL rst_flush got=%b want=0", flush); end
    rst = 0;
    tick();
    chk_pc("rel0", 32'h0);
    checks++;
    if (fv !== 1'b1) begin errors++; $display("FAIL rel_fv got=%b want=1", fv); end
    tick();
    chk_pc("rel1", 32'h4);
    tick();
    chk_pc("rel2", 32'h8);
    checks++;
    if (flush !== 1'b0) begin errors++; $display("FAIL rel_flush got=%b want=0", flush); end
  endtask

  task automatic test_branch();
    tick();
    tick();
    chk_pc("seq10", 32'h10);
    br = 1; br_tgt = 32'h40;
    tick();
    br = 0;
    chk_pc("br", 32'h40);
    checks++;
    if (pc4 !== 32'h44) begin errors++; $display("FAIL br_pc4 got=%h want=44", pc4); end
    checks++;
    if (flush !== 1'b1) begin errors++; $display("FAIL br_flush got=%b want=1", flush); end
    tick();
    chk_pc("br_next", 32'h44);
    checks++;
    if (flush !== 1'b0) begin errors++; $display("FAIL br_flush_end got=%b want=0", flush); end
  endtask

  task automatic test_stall_pending();
    stall = 1; jp = 1; jp_tgt = 32'h200;
    tick();
    jp = 0;
    chk_pc("st1", 32'h44);
    br = 1; br_tgt = 32'h100;
    tick();
    br = 0;
    chk_pc("st2", 32'h44);
    tick();
    chk_pc("st3", 32'h44);
    checks++;
    if (pc4 !== 32'h48) begin errors++; $display("FAIL st_pc4 got=%h want=48", pc4); end
    checks++;
    if (fv !== 1'b1 || flush !== 1'b0) begin
      errors++; $display("FAIL st_flags got=%b%b want=10", fv, flush);
    end
    stall = 0;
    tick();
    chk_pc("st_rel", 32'h100);
    checks++;
    if (flush !== 1'b1) begin errors++; $display("FAIL st_rel_flush got=%b want=1", flush); end
    tick();
    chk_pc("st_after", 32'h104);
    checks++;
    if (flush !== 1'b0) begin errors++; $display("FAIL st_after_flush got=%b want=0", flush); end
    // branch buffered first must survive a later jump
    stall = 1; br = 1; br_tgt = 32'h180;
    tick();
    br = 0; jp = 1; jp_tgt = 32'h280;
    tick();
    jp = 0; stall = 0;
    tick();
    chk_pc("br_keep", 32'h180);
    // buffered jump beats a live jump at release
    stall = 1; jp = 1; jp_tgt = 32'h200;
    tick();
    stall = 0; jp_tgt = 32'h300;
    tick();
    jp = 0;
    chk_pc("pend_gt_jump", 32'h200);
  endtask

  task automatic test_simultaneous();
    br = 1; br_tgt = 32'h80; jp = 1; jp_tgt = 32'h300;
    tick();
    idle();
    chk_pc("simul", 32'h80);
    jp = 1; jp_tgt = 32'h300;
    tick();
    jp = 0;
    chk_pc("jump", 32'h300);
  endtask

  task automatic test_wrap();
    br = 1; br_tgt = 32'hFFFF_FFFC;
    tick();
    br = 0;
    chk_pc("wrap0", 32'hFFFF_FFFC);
    checks++;
    if (pc4 !== 32'h0) begin errors++; $display("FAIL wrap0_pc4 got=%h want=0", pc4); end
    tick();
    chk_pc("wrap1", 32'h0);
    checks++;
    if (pc4 !== 32'h4 || flush !== 1'b0) begin
      errors++; $display("FAIL wrap1 pc4=%h flush=%b want 4/0", pc4, flush);
    end
  endtask

  task automatic test_align();
    logic [31:0] want;
`ifdef PC_SEQ_ALIGN_CHECK_EN
    want = 32'h80;
`else
    want = 32'h40;
`endif
    br = 1; br_tgt = 32'h42;
    tick();
    br = 0;
    chk_pc("align", want);
    checks++;
    if (flush !== 1'b1) begin errors++; $display("FAIL align_flush got=%b want=1", flush); end
`ifdef PC_SEQ_ALIGN_CHECK_EN
    checks++;
    if (mis !== 1'b1) begin errors++; $display("FAIL align_mis got=%b want=1", mis); end
`endif
    tick();
    checks++;
    if (mis !== 1'b0) begin errors++; $display("FAIL align_mis_end got=%b want=0", mis); end
    stall = 1; jp = 1; jp_tgt = 32'h43;
    tick();
    jp = 0; stall = 0;
    tick();
`ifdef PC_SEQ_ALIGN_CHECK_EN
    want = 32'h80;
`else
    want = 32'h40;
`endif
    chk_pc("align_pend", want);
  endtask

  task automatic test_reset_pending();
    stall = 1; jp = 1; jp_tgt = 32'h300;
    tick();
    jp = 0;
    rst = 1;
    tick();
    chk_pc("rp_rst", 32'h0);
    checks++;
    if (fv !== 1'b0) begin errors++; $display("FAIL rp_fv got=%b want=0", fv); end
    rst = 0; stall = 0;
    tick();
    chk_pc("rp0", 32'h0);
    tick();
    chk_pc("rp1", 32'h4);
    checks++;
    if (flush !== 1'b0) begin errors++; $display("FAIL rp_flush got=%b want=0", flush); end
  endtask

  initial begin
    rst = 1;
    idle();
    test_reset();
    test_branch();
    test_stall_pending();
    test_simultaneous();
    test_wrap();
    test_align();
    test_reset_pending();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
